div_arbiter: RTL and testbench

Controller that shares the single 8-bit restoring divider between two requesting clients. It arbitrates round-robin, latches the winner's operands, and loads them into the divider's operand registers. It then pulses the divider start, waits for completion under a watchdog, and returns quotient/remainder to the winner with a one-cycle acknowledge. Zero divisors are resolved locally without starting the divider.

---
 rtl/div_arbiter_if.sv | 38 +++
 rtl/div_arbiter.sv | 133 +++++++++++++
 tb/tb_div_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_arbiter_if.sv
// Client request/response and divider-control signals of the shared-divider
// arbiter. The arbiter is the slave of the clients and drives the divider.
interface div_arbiter_if;
  logic       req0;
  logic       req1;
  logic [7:0] a0;
  logic [7:0] b0;
  logic [7:0] a1;
  logic [7:0] b1;
  logic       ack0;
  logic       ack1;
  logic [7:0] res_q;
  logic [8:0] res_r;
  logic       res_err;
  logic       busy;
  logic       owner;
  logic [2:0] state;
  logic [7:0] div_A;
  logic [7:0] div_B;
  logic       div_enA;
  logic       div_enB;
  logic       div_ini;
  logic       div_end;
  logic [7:0] div_q;
  logic [8:0] div_r;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, div_end, div_q, div_r,
    output ack0, ack1, res_q, res_r, res_err, busy, owner, state,
           div_A, div_B, div_enA, div_enB, div_ini
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, div_end, div_q, div_r,
    input  ack0, ack1, res_q, res_r, res_err, busy, owner, state,
           div_A, div_B, div_enA, div_enB, div_ini
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one 8-bit divider between two clients, with a
// watchdog on divider completion and local handling of zero divisors.
module div_arbiter #(
  parameter int unsigned WD_LIMIT = 40
) (
  input  logic          clk,
  input  logic          rst,
  div_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam int unsigned       WD_W   = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0]   WD_MAX = WD_W'(WD_LIMIT);

  state_t          state_q;
  logic            last_grant;
  logic [WD_W-1:0] wd;

  logic            grant_valid;
  logic            grant_id;
  logic [7:0]      sel_a;
  logic [7:0]      sel_b;

  // On a tie the client that was not served last wins.
  assign grant_valid = bus.req0 | bus.req1;
  assign grant_id    = bus.req1 & (~bus.req0 | ~last_grant);
  assign sel_a       = grant_id ? bus.a1 : bus.a0;
  assign sel_b       = grant_id ? bus.b1 : bus.b0;

  assign bus.state   = state_q;

  // NOTE: every output is a register updated with <= so all of them change
  // together on the edge; the pulse outputs default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_grant  <= 1'b1;
      wd          <= '0;
      bus.ack0    <= 1'b0;
      bus.ack1    <= 1'b0;
      bus.res_q   <= '0;
      bus.res_r   <= '0;
      bus.res_err <= 1'b0;
      bus.busy    <= 1'b0;
      bus.owner   <= 1'b0;
      bus.div_A   <= '0;
      bus.div_B   <= '0;
      bus.div_enA <= 1'b0;
      bus.div_enB <= 1'b0;
      bus.div_ini <= 1'b0;
    end else begin
      bus.ack0    <= 1'b0;
      bus.ack1    <= 1'b0;
      bus.div_enA <= 1'b0;
      bus.div_enB <= 1'b0;
      bus.div_ini <= 1'b0;

      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            bus.owner <= grant_id;
            bus.busy  <= 1'b1;
            if (sel_b != 8'd0) begin
              state_q     <= LOAD;
              bus.div_A   <= sel_a;
              bus.div_B   <= sel_b;
              bus.div_enA <= 1'b1;
              bus.div_enB <= 1'b1;
            end else begin
              // Divide-by-zero is answered without touching the divider.
              state_q     <= RESP;
              bus.res_q   <= 8'hFF;
              bus.res_r   <= {1'b0, sel_a};
              bus.res_err <= 1'b1;
              bus.ack0    <= ~grant_id;
              bus.ack1    <= grant_id;
            end
          end
        end

        LOAD: begin
          state_q     <= START;
          bus.div_ini <= 1'b1;
        end

        START: begin
          state_q <= WAIT;
          wd      <= '0;
        end

        WAIT: begin
          // Completion takes priority over a watchdog expiring in the same cycle.
          if (bus.div_end) begin
            state_q     <= RESP;
            bus.res_q   <= bus.div_q;
            bus.res_r   <= bus.div_r;
            bus.res_err <= 1'b0;
            bus.ack0    <= ~bus.owner;
            bus.ack1    <= bus.owner;
          end else if (wd == WD_MAX) begin
            state_q     <= RESP;
            bus.res_q   <= 8'hFF;
            bus.res_r   <= 9'h1FF;
            bus.res_err <= 1'b1;
            bus.ack0    <= ~bus.owner;
            bus.ack1    <= bus.owner;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        RESP: begin
          state_q    <= IDLE;
          bus.busy   <= 1'b0;
          last_grant <= bus.owner;
        end

        default: begin
          state_q  <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed and randomized bench for div_arbiter: an emulated divider answers
// after a chosen delay and a high-level model predicts result, winner and latency.
module tb_div_arbiter;

  localparam int WD_LIMIT = 40;

  typedef struct packed {
    logic [7:0] q;
    logic [8:0] r;
    logic       err;
  } res_t;

  logic clk;
  logic rst;
  div_arbiter_if bus ();

  div_arbiter #(.WD_LIMIT(WD_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Emulated divider: latches operands on their enables, answers div_delay
  // WAIT cycles after the start pulse; a negative delay means never.
  int         div_delay = 0;
  int         cnt;
  bit         counting;
  logic [7:0] lat_a, lat_b;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      bus.div_end = 1'b0;
      bus.div_q   = '0;
      bus.div_r   = '0;
      counting    = 1'b0;
      cnt         = 0;
    end else begin
      bus.div_end = 1'b0;
      if (bus.div_enA) lat_a = bus.div_A;
      if (bus.div_enB) lat_b = bus.div_B;
      if (bus.div_ini) begin
        counting = 1'b1;
        cnt      = div_delay;
      end else if (counting) begin
        if (cnt == 0) begin
          bus.div_end = 1'b1;
          bus.div_q   = (lat_b == 0) ? 8'hFF : lat_a / lat_b;
          bus.div_r   = (lat_b == 0) ? 9'h1FF : {1'b0, lat_a % lat_b};
          counting    = 1'b0;
        end else if (cnt > 0) begin
          cnt--;
        end
      end
    end
  end

  // Pulse counters, sampled mid-cycle.
  int n_ack0 = 0, n_ack1 = 0, n_ena = 0, n_enb = 0, n_ini = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ack0)    n_ack0++;
      if (bus.ack1)    n_ack1++;
      if (bus.div_enA) n_ena++;
      if (bus.div_enB) n_enb++;
      if (bus.div_ini) n_ini++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input int n);
    res_t e;
    if (b == 8'd0)                 e = '{8'hFF, {1'b0, a}, 1'b1};
    else if (n < 0 || n > WD_LIMIT) e = '{8'hFF, 9'h1FF, 1'b1};
    else                           e = '{a / b, {1'b0, a % b}, 1'b0};
    return e;
  endfunction

  function automatic int latency(input logic [7:0] b, input int n);
    if (b == 8'd0)                  return 1;
    if (n < 0 || n > WD_LIMIT)      return WD_LIMIT + 4;
    return n + 4;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(output int cyc, output logic [1:0] acks);
    cyc  = 0;
    acks = 2'b00;
    while (cyc < 200) begin
      tick();
      cyc++;
      if (bus.ack0 || bus.ack1) begin
        acks = {bus.ack1, bus.ack0};
        break;
      end
    end
  endtask

  // Waits for the ack of client 'who', checks it, optionally drops that
  // client's request, then checks the block is idle with results held.
  task automatic expect_op(input string tag, input logic who, input logic [7:0] a,
                           input logic [7:0] b, input int n, input bit chk_lat,
                           input bit drop);
    int         cyc;
    logic [1:0] acks;
    res_t       e;
    e = model(a, b, n);
    wait_ack(cyc, acks);
    check({tag, ".ack"}, 64'(acks), who ? 64'd2 : 64'd1);
    if (chk_lat) check({tag, ".lat"}, 64'(cyc), 64'(latency(b, n)));
    check({tag, ".res"}, 64'({bus.res_q, bus.res_r, bus.res_err}), 64'(e));
    check({tag, ".owner"}, 64'(bus.owner), 64'(who));
    if (drop) begin
      if (who) bus.req1 = 1'b0;
      else     bus.req0 = 1'b0;
    end
    tick();
    check({tag, ".idle"},
          64'({bus.state, bus.busy, bus.ack0, bus.ack1, bus.res_q, bus.res_r, bus.res_err}),
          64'({3'd0, 1'b0, 1'b0, 1'b0, e}));
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({bus.ack0, bus.ack1, bus.res_q, bus.res_r, bus.res_err, bus.busy,
                bus.owner, bus.state, bus.div_A, bus.div_B, bus.div_enA,
                bus.div_enB, bus.div_ini});
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int s_ack0, s_ack1, s_ena, s_enb, s_ini;
    logic       c;
    logic [7:0] ra, rb;
    int         rn;

    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    repeat (3) tick();
    check("reset.outputs", all_outputs(), 64'd0);
    rst = 1'b0;
    tick();

    // Tie from reset: client 0, then 1, then 0 again while req0 stays high.
    div_delay = 3;
    bus.a0 = 8'd50; bus.b0 = 8'd5; bus.a1 = 8'd9; bus.b1 = 8'd4;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    expect_op("rr.first", 1'b0, 8'd50, 8'd5, 3, 1'b1, 1'b0);
    bus.a0 = 8'd20; bus.b0 = 8'd6;
    expect_op("rr.second", 1'b1, 8'd9, 8'd4, 3, 1'b0, 1'b1);
    expect_op("rr.third", 1'b0, 8'd20, 8'd6, 3, 1'b0, 1'b1);

    // Single request, divider answers after 9 WAIT cycles.
    s_ack1 = n_ack1; s_ena = n_ena; s_enb = n_enb; s_ini = n_ini;
    div_delay = 9;
    bus.a0 = 8'd100; bus.b0 = 8'd7; bus.req0 = 1'b1;
    expect_op("single", 1'b0, 8'd100, 8'd7, 9, 1'b1, 1'b1);
    check("single.pulses", 64'({n_ena - s_ena, n_enb - s_enb, n_ini - s_ini}),
          64'({32'd1, 32'd1, 32'd1}) & 64'hFFFF_FFFF_FFFF_FFFF);
    check("single.operands", 64'({lat_a, lat_b}), 64'({8'd100, 8'd7}));
    check("single.no_ack1", 64'(n_ack1 - s_ack1), 64'd0);

    // Zero divisor on client 1.
    s_ena = n_ena; s_enb = n_enb; s_ini = n_ini;
    bus.a1 = 8'h3C; bus.b1 = 8'd0; bus.req1 = 1'b1;
    expect_op("zero", 1'b1, 8'h3C, 8'd0, 0, 1'b1, 1'b1);
    check("zero.no_divider", 64'({n_ena - s_ena, n_enb - s_enb, n_ini - s_ini}), 64'd0);

    // Watchdog: never, exactly at the limit, one past the limit.
    div_delay = -1;
    bus.a0 = 8'd33; bus.b0 = 8'd3; bus.req0 = 1'b1;
    expect_op("timeout", 1'b0, 8'd33, 8'd3, -1, 1'b1, 1'b1);
    div_delay = WD_LIMIT;
    bus.a1 = 8'd255; bus.b1 = 8'd16; bus.req1 = 1'b1;
    expect_op("wd_edge", 1'b1, 8'd255, 8'd16, WD_LIMIT, 1'b1, 1'b1);
    div_delay = WD_LIMIT + 1;
    bus.a0 = 8'd7; bus.b0 = 8'd2; bus.req0 = 1'b1;
    expect_op("wd_over", 1'b0, 8'd7, 8'd2, WD_LIMIT + 1, 1'b1, 1'b1);

    // Reset during WAIT, then the held request is served afresh.
    div_delay = 20;
    bus.a0 = 8'd200; bus.b0 = 8'd3; bus.req0 = 1'b1;
    repeat (6) tick();
    check("rst_mid.in_wait", 64'(bus.state), 64'd3);
    s_ack0 = n_ack0;
    rst = 1'b1;
    #1;
    check("rst_mid.outputs", all_outputs(), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    check("rst_mid.no_ack", 64'(n_ack0 - s_ack0), 64'd0);
    div_delay = 5;
    expect_op("rst_mid.reserve", 1'b0, 8'd200, 8'd3, 5, 1'b1, 1'b1);

    // Operand changes after grant are ignored.
    div_delay = 10;
    bus.a0 = 8'd77; bus.b0 = 8'd6; bus.req0 = 1'b1;
    repeat (5) tick();
    bus.a0 = 8'd1; bus.b0 = 8'd0;
    expect_op("opchange", 1'b0, 8'd77, 8'd6, 10, 1'b0, 1'b1);

    // Randomized single-client operations.
    for (int i = 0; i < 10; i++) begin
      c  = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rn = $urandom_range(0, 12);
      div_delay = rn;
      if (c) begin bus.a1 = ra; bus.b1 = rb; bus.req1 = 1'b1; end
      else   begin bus.a0 = ra; bus.b0 = rb; bus.req0 = 1'b1; end
      expect_op($sformatf("rand%0d", i), c, ra, rb, rn, 1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
